fire3_squeeze_bias_relu: RTL and testbench
==========================================

FIRE3_SQUEEZE_BIAS_RELU -- requirements
Module: fire3_squeeze_bias_relu

Interface
REQ-001 Parameter NUM_CH, default 16: number of output channels; also the per-pixel channel cycle length.
REQ-002 Parameter ACC_W, default 32: signed accumulator and bias width.
REQ-003 Parameter OUT_W, default 16: signed output activation width.
REQ-004 Parameter SHIFT, default 8: arithmetic right-shift applied after the bias add.
REQ-005 Parameter PIXELS, default 3025: pixels per frame (55x55).
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 bias_mem  input  ACC_W x [0:NUM_CH-1]  per-channel signed bias constants; static during operation.
REQ-009 acc_in  input  ACC_W  signed convolution accumulator for the current channel.
REQ-010 acc_valid  input  1  acc_in is valid this cycle.
REQ-011 acc_ready  output  1  block accepts acc_in this cycle.
REQ-012 act_out  output  OUT_W  signed post-bias, post-ReLU activation.
REQ-013 act_valid  output  1  act_out is valid.
REQ-014 act_ready  input  1  downstream accepts act_out.
REQ-015 act_ch  output  log2(NUM_CH)  channel index of act_out.
REQ-016 act_last  output  1  act_out is the last channel of the last pixel of the frame.

Function
REQ-017 An input beat is accepted when acc_valid and acc_ready are both 1; an output beat is accepted when act_valid and act_ready are both 1.
REQ-018 The datapath SHALL be a 2-stage pipeline with a global advance enable en = !act_valid || act_ready; acc_ready SHALL equal en.
REQ-019 Stage 1 on en: s1_sum = sign-extended acc_in + sign-extended bias_mem[ch_cnt], computed at ACC_W+1 bits with no wrap; s1_valid = input accept; s1_ch = ch_cnt; s1_last = (ch_cnt == NUM_CH-1 && pix_cnt == PIXELS-1).
REQ-020 Stage 2 on en: s = s1_sum >>> SHIFT (arithmetic); if s < 0, act_out = 0; else if s > 2^(OUT_W-1)-1, act_out = 2^(OUT_W-1)-1; else act_out = s[OUT_W-1:0]; act_valid, act_ch and act_last load from stage 1.
REQ-021 When en = 0, all pipeline registers and counters SHALL hold their values; act_out and act_ch SHALL stay stable while act_valid = 1 and act_ready = 0.
REQ-022 ch_cnt SHALL increment on each input accept and wrap from NUM_CH-1 to 0.
REQ-023 pix_cnt SHALL increment when ch_cnt wraps and wrap from PIXELS-1 to 0, so the next frame starts at pixel 0, channel 0 with no gap.
REQ-024 Latency SHALL be 2 cycles from input accept to act_valid with act_ready held 1; throughput SHALL be 1 beat per cycle.
REQ-025 Input bubbles (acc_valid = 0) SHALL propagate as act_valid = 0 and SHALL NOT advance the counters.
REQ-026 act_last SHALL be 1 on exactly one output beat per frame: channel NUM_CH-1 of pixel PIXELS-1.

Reset
REQ-027 While rst_n = 0: s1_valid = 0, act_valid = 0, act_out = 0, act_ch = 0, act_last = 0, ch_cnt = 0, pix_cnt = 0; all asynchronous.
REQ-028 acc_ready SHALL be 1 during and immediately after reset, because act_valid = 0.
REQ-029 A reset asserted mid-frame SHALL discard in-flight beats; the first beat accepted after release is channel 0 of pixel 0.

Verification
REQ-030 bias_mem[0] = 1079; acc_in = 4096 on channel 0 -> act_out = 20, act_ch = 0, two cycles after accept.
REQ-031 bias_mem[1] = -66; acc_in = 0 on channel 1 -> sum -66, shift gives -1, act_out = 0 (ReLU clamp).
REQ-032 acc_in = 0x7FFF0000 with bias 0 -> act_out = 0x7FFF (saturation); acc_in = 0x7FFFFFFF with bias 0x7FFFFFFF -> act_out = 0x7FFF (no add wrap).
REQ-033 16 consecutive beats with act_ready = 1 -> act_ch = 0..15 in order, then 0 again; act_last = 0 throughout.
REQ-034 act_ready = 0 for 5 cycles during streaming -> acc_ready = 0 within 2 accepted beats; no beat lost or duplicated; act_out stays stable while stalled.
REQ-035 Full frame of PIXELS*NUM_CH beats -> act_last = 1 only on beat 48400, followed by a second frame starting at channel 0; rst_n pulsed low mid-frame -> act_valid = 0 at once and counters restart at 0.

Source files
------------

// File: rtl/fire3_squeeze_bias_relu.sv
// Per-channel bias add, arithmetic shift and saturating ReLU for the fire3 squeeze layer; 2-cycle latency.
// Backpressure: one global advance enable stalls the whole pipeline; acc_ready drops while an output is held.
module fire3_squeeze_bias_relu #(
   parameter int NUM_CH = 16,
   parameter int ACC_W  = 32,
   parameter int OUT_W  = 16,
   parameter int SHIFT  = 8,
   parameter int PIXELS = 3025,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [ACC_W-1:0] bias_mem [0:NUM_CH-1],
   input  logic signed [ACC_W-1:0] acc_in,
   input  logic                    acc_valid,
   output logic                    acc_ready,
   output logic signed [OUT_W-1:0] act_out,
   output logic                    act_valid,
   input  logic                    act_ready,
   output logic [CH_W-1:0]         act_ch,
   output logic                    act_last
);

   localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(NUM_CH - 1);
   localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(PIXELS - 1);
   localparam logic signed [ACC_W:0] OUT_MAX =
      {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};

   logic                    en;
   logic                    in_acc;
   logic [CH_W-1:0]         ch_cnt;
   logic [PIX_W-1:0]        pix_cnt;
   logic                    ch_wrap;
   logic                    pix_wrap;
   logic signed [ACC_W-1:0] bias_sel;
   logic signed [ACC_W:0]   sum_c;

   logic signed [ACC_W:0]   s1_sum;
   logic                    s1_valid;
   logic [CH_W-1:0]         s1_ch;
   logic                    s1_last;

   logic signed [ACC_W:0]   shifted;
   logic signed [OUT_W-1:0] relu_c;

   assign en        = !act_valid || act_ready;
   assign acc_ready = en;
   assign in_acc    = acc_valid && en;
   assign ch_wrap   = (ch_cnt == CH_MAX);
   assign pix_wrap  = (pix_cnt == PIX_MAX);

   // One extra bit of headroom so the bias add can never wrap.
   assign bias_sel = bias_mem[ch_cnt];
   assign sum_c    = {acc_in[ACC_W-1], acc_in} + {bias_sel[ACC_W-1], bias_sel};
   assign shifted  = s1_sum >>> SHIFT;

   always_comb begin
      relu_c = '0;
      if (shifted[ACC_W]) begin
         relu_c = '0;
      end else if (shifted > OUT_MAX) begin
         relu_c = OUT_MAX[OUT_W-1:0];
      end else begin
         relu_c = shifted[OUT_W-1:0];
      end
   end

   // Channel/pixel position of the next accepted beat; bubbles leave it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_cnt  <= '0;
         pix_cnt <= '0;
      end else if (in_acc) begin
         ch_cnt <= ch_wrap ? '0 : ch_cnt + 1'b1;
         if (ch_wrap) begin
            pix_cnt <= pix_wrap ? '0 : pix_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_sum   <= '0;
         s1_valid <= 1'b0;
         s1_ch    <= '0;
         s1_last  <= 1'b0;
      end else if (en) begin
         s1_sum   <= sum_c;
         s1_valid <= in_acc;
         s1_ch    <= ch_cnt;
         s1_last  <= ch_wrap && pix_wrap;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_out   <= '0;
         act_valid <= 1'b0;
         act_ch    <= '0;
         act_last  <= 1'b0;
      end else if (en) begin
         act_out   <= relu_c;
         act_valid <= s1_valid;
         act_ch    <= s1_ch;
         act_last  <= s1_last;
      end
   end

endmodule

// File: tb/tb_fire3_squeeze_bias_relu.sv
// Directed bench for fire3_squeeze_bias_relu: latency, clamping, channel order, stalls, reset and frame marker.
module tb_fire3_squeeze_bias_relu;

   localparam int NUM_CH = 16;
   localparam int PIXELS = 3025;
   localparam int FRAME  = NUM_CH * PIXELS;

   logic               clk = 1'b0;
   logic               rst_n;
   logic signed [31:0] bias_mem [0:NUM_CH-1];
   logic signed [31:0] acc_in;
   logic               acc_valid;
   logic               acc_ready;
   logic signed [15:0] act_out;
   logic               act_valid;
   logic               act_ready;
   logic [3:0]         act_ch;
   logic               act_last;

   int          n_vec = 0;
   int          n_err = 0;
   logic [20:0] exp_q [$];
   int          exp_ch = 0;
   int          exp_pix = 0;
   int          stall_left = 0;
   int          last_cnt = 0;
   int          beat_idx = 0;
   bit          after_last = 1'b0;
   bit          prev_stall = 1'b0;
   logic [15:0] prev_out;
   logic [3:0]  prev_ch;

   always #5 clk = ~clk;

   fire3_squeeze_bias_relu #(
      .NUM_CH(NUM_CH), .ACC_W(32), .OUT_W(16), .SHIFT(8), .PIXELS(PIXELS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bias_mem(bias_mem),
      .acc_in(acc_in), .acc_valid(acc_valid), .acc_ready(acc_ready),
      .act_out(act_out), .act_valid(act_valid), .act_ready(act_ready),
      .act_ch(act_ch), .act_last(act_last)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic logic [15:0] ref_act(input logic signed [31:0] acc, input logic signed [31:0] b);
      logic signed [32:0] sum;
      logic signed [32:0] s;
      sum = {acc[31], acc} + {b[31], b};
      s   = sum >>> 8;
      if (s < 0) return 16'h0000;
      if (s > 33'sd32767) return 16'h7FFF;
      return s[15:0];
   endfunction

   task automatic push_exp(input logic [15:0] out);
      logic last;
      last = (exp_ch == NUM_CH - 1) && (exp_pix == PIXELS - 1);
      exp_q.push_back({last, 4'(exp_ch), out});
      exp_ch++;
      if (exp_ch == NUM_CH) begin
         exp_ch  = 0;
         exp_pix = (exp_pix == PIXELS - 1) ? 0 : exp_pix + 1;
      end
   endtask

   task automatic apply_rdy();
      act_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
   endtask

   task automatic send(input logic signed [31:0] acc, input logic [15:0] want);
      int waited = 0;
      @(negedge clk);
      apply_rdy();
      acc_valid = 1'b1;
      acc_in    = acc;
      #1;
      while (!acc_ready) begin
         check("stall_cause", {act_valid, act_ready}, 2'b10);
         waited++;
         if (waited > 50) begin
            check("accept_timeout", 0, 1);
            break;
         end
         @(negedge clk);
         apply_rdy();
         #1;
      end
      if (acc_ready) push_exp(want);
   endtask

   task automatic send_m(input logic signed [31:0] acc);
      send(acc, ref_act(acc, bias_mem[exp_ch]));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         apply_rdy();
         acc_valid = 1'b0;
      end
   endtask

   function automatic logic signed [31:0] rnd_acc();
      return int'($urandom_range(400000)) - 100000;
   endfunction

   // Output monitor: scoreboard compare, hold stability and frame-marker tracking.
   always begin
      logic [20:0] e;
      @(negedge clk);
      #2;
      if (rst_n) begin
         if (prev_stall) begin
            check("hold_vld", act_valid, 1);
            check("hold_dat", {act_ch, act_out}, {prev_ch, prev_out});
         end
         if (act_valid && act_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               beat_idx++;
               check("beat", {act_last, act_ch, act_out}, e);
               if (after_last) begin
                  check("frame2_ch", act_ch, 0);
                  after_last = 1'b0;
               end
               if (act_last) begin
                  last_cnt++;
                  check("last_idx", beat_idx, FRAME);
                  after_last = 1'b1;
               end
            end
         end
         prev_stall = act_valid && !act_ready;
         prev_out   = act_out;
         prev_ch    = act_ch;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      int t;
      for (int c = 0; c < NUM_CH; c++) bias_mem[c] = c * 100 - 700;
      bias_mem[0] = 32'sd1079;
      bias_mem[1] = -32'sd66;
      bias_mem[2] = 32'sd0;
      bias_mem[3] = 32'sh7FFFFFFF;
      rst_n     = 1'b0;
      acc_valid = 1'b0;
      acc_in    = '0;
      act_ready = 1'b1;

      #12;
      check("rst_vld", act_valid, 0);
      check("rst_out", act_out, 0);
      check("rst_ch", act_ch, 0);
      check("rst_last", act_last, 0);
      check("rst_rdy", acc_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_rdy", acc_ready, 1);

      // 4096 + 1079 = 5175, >>> 8 = 20; arrives on the second edge after accept.
      send(32'sd4096, 16'd20);
      @(negedge clk);
      acc_valid = 1'b0;
      #1;
      check("lat1_vld", act_valid, 0);
      @(negedge clk);
      #1;
      check("lat2_vld", act_valid, 1);
      check("lat2_out", act_out, 20);
      check("lat2_ch", act_ch, 0);
      @(negedge clk);
      #1;
      check("bubble_vld", act_valid, 0);

      send(32'sd0, 16'd0);
      send(32'sh7FFF0000, 16'h7FFF);
      send(32'sh7FFFFFFF, 16'h7FFF);
      for (int i = 4; i < 3 * NUM_CH + 1; i++) send_m(rnd_acc());

      for (int i = 0; i < 10; i++) send_m(rnd_acc());
      stall_left = 5;
      for (int i = 0; i < 10; i++) send_m(rnd_acc());
      idle(4);

      for (int i = 0; i < 5; i++) send_m(rnd_acc());
      @(negedge clk);
      rst_n     = 1'b0;
      acc_valid = 1'b0;
      #1;
      check("arst_vld", act_valid, 0);
      check("arst_out", act_out, 0);
      check("arst_ch", act_ch, 0);
      check("arst_rdy", acc_ready, 1);
      exp_q.delete();
      exp_ch   = 0;
      exp_pix  = 0;
      beat_idx = 0;
      last_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < FRAME + NUM_CH; i++) send_m(rnd_acc());

      t = 0;
      while (exp_q.size() != 0 && t < 20) begin
         idle(1);
         t++;
      end
      idle(2);
      check("drain", exp_q.size(), 0);
      check("last_cnt", last_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
